crc_stream_gen: RTL

CRC_STREAM_GEN -- requirements
Module: crc_stream_gen

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_step.sv | 32 +++
 rtl/crc_stream_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream generator: FSM state encoding,
// well-known generator polynomials and a small sizing helper.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2
    } crc_state_e;

    localparam logic [15:0] CRC16_8005     = 16'h8005;
    localparam logic [15:0] CRC16_1021     = 16'h1021;
    localparam logic [31:0] CRC32_04C11DB7 = 32'h04C11DB7;

    // Number of stream words needed to carry one CRC value.
    function automatic int crc_words(input int crc_w, input int data_w);
        return crc_w / data_w;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational single-cycle CRC update: folds all DATA_W bits of one word
// into the CRC register, most-significant data bit first.
module crc_step
    import crc_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_8005)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] c;
    logic             fb;

    // Unrolled bit-serial LFSR: one shift/conditional-XOR per data bit.
    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_gen.sv
// Streaming CRC generator: passes each frame through a one-entry output
// register and appends the frame CRC (CRC_W/DATA_W words) after the last
// data word. Optional input/output reflection is built only when the macro
// CRC_REFLECT_EN is defined (adds parameters REFIN and REFOUT).
module crc_stream_gen
    import crc_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_8005),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
`ifdef CRC_REFLECT_EN
    ,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  crc_value,
    output logic              crc_done
);

    localparam int NWORDS = crc_words(CRC_W, DATA_W);
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    crc_state_e        state, state_nxt;
    logic [CRC_W-1:0]  crc_acc, crc_base, crc_next, crc_final, crc_shift;
    logic [DATA_W-1:0] step_data, crc_word;
    logic [CNT_W-1:0]  word_cnt;
    logic              vld_p1, last_p1;
    logic [DATA_W-1:0] data_p1;
    logic              accept, emit, load_crc, final_emit;

`ifdef CRC_REFLECT_EN
    function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] d);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = d[CRC_W-1-i];
        end
        return r;
    endfunction
`endif

    assign s_ready    = (state != ST_APPEND) && (!vld_p1 || m_ready);
    assign accept     = s_valid && s_ready;
    assign emit       = vld_p1 && m_ready;
    assign final_emit = (state == ST_APPEND) && emit && last_p1;
    // Refill the output register with the next CRC word once it is free,
    // but never past the word flagged as last.
    assign load_crc   = (state == ST_APPEND) && (!vld_p1 || m_ready) && !(vld_p1 && last_p1);

    // A frame starts from INIT: any word accepted in IDLE is a first word.
    assign crc_base = (state == ST_IDLE) ? INIT : crc_acc;

    // Word-order, reflection and final XOR around the shared update core.
    always_comb begin
`ifdef CRC_REFLECT_EN
        step_data = REFIN ? rev_data(s_data) : s_data;
        crc_final = (REFOUT ? rev_crc(crc_next) : crc_next) ^ XOR_OUT;
        if (REFOUT) begin
            crc_shift = crc_value >> (int'(word_cnt) * DATA_W);
        end else begin
            crc_shift = crc_value >> ((NWORDS - 1 - int'(word_cnt)) * DATA_W);
        end
`else
        step_data = s_data;
        crc_final = crc_next ^ XOR_OUT;
        crc_shift = crc_value >> ((NWORDS - 1 - int'(word_cnt)) * DATA_W);
`endif
        crc_word = crc_shift[DATA_W-1:0];
    end

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_base),
        .data    (step_data),
        .crc_out (crc_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: frame start, last data word, last CRC word out.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = s_last ? ST_APPEND : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && s_last) begin
                    state_nxt = ST_APPEND;
                end
            end
            ST_APPEND: begin
                if (final_emit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // CRC accumulator; the finished CRC is latched as the last word enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc   <= INIT;
            crc_value <= '0;
        end else if (accept) begin
            crc_acc <= crc_next;
            if (s_last) begin
                crc_value <= crc_final;
            end
        end else if (final_emit) begin
            crc_acc <= INIT;
        end
    end

    // ---- stage p1: one-entry output register (data echo, then CRC words) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            data_p1  <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            last_p1  <= 1'b0;
            data_p1  <= s_data;
            word_cnt <= '0;
        end else if (load_crc) begin
            vld_p1   <= 1'b1;
            last_p1  <= (word_cnt == CNT_W'(NWORDS - 1));
            data_p1  <= crc_word;
            word_cnt <= word_cnt + 1'b1;
        end else if (emit) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    // One-cycle completion pulse after the final CRC word leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_done <= 1'b0;
        end else begin
            crc_done <= final_emit;
        end
    end

    assign m_valid = vld_p1;
    assign m_data  = data_p1;
    assign m_last  = last_p1;

endmodule
